// File: rtl/acc_loop_sequencer_pkg.sv
// Shared definitions for the accumulator loop sequencer: FSM encoding,
// default pipeline/depth constants matching the accumulator, and the
// loop-flag bundle carried down the MAC-latency delay line.
package acc_loop_sequencer_pkg;

  // Partial-sum memory depth and MAC pipeline latency of the accumulator
  localparam int ACC_HEIGHT_NUM_DEF = 16;
  localparam int MAC_LAT_DEF        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // One issue beat's worth of loop flags, travelling with its valid
  typedef struct packed {
    logic vld;
    logic hle;
    logic alm;
    logic ahle;
  } flag_t;

  localparam int FLAG_W = $bits(flag_t);

endpackage

// File: rtl/acc_flag_delay.sv
// Fixed-depth shift register that delays the loop-flag bundle by the MAC
// pipeline latency so the flags land alongside the partial-sum valid.
module acc_flag_delay
  import acc_loop_sequencer_pkg::*;
#(
  parameter int DEPTH = MAC_LAT_DEF,
  parameter int W     = FLAG_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_p [DEPTH];

  // Shift one stage per cycle; reset empties every stage so no stale flag survives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
    end else begin
      stage_p[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
    end
  end

  assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/acc_loop_sequencer.sv
// Accumulator loop sequencer: walks the height (inner), acc (middle) and
// output-tile (outer) loops, issues one MAC beat per loop point over a
// valid/ready handshake, delays the accumulator loop flags by MAC_LAT, and
// counts accumulator output beats to signal layer completion.
// Optional build macro ACC_LOOP_SEQ_PERF_EN adds saturating stall and busy
// cycle counters (perf_stall_cnt, perf_cycle_cnt).
module acc_loop_sequencer
  import acc_loop_sequencer_pkg::*;
#(
  parameter int MAC_LAT        = MAC_LAT_DEF,
  parameter int ACC_HEIGHT_NUM = ACC_HEIGHT_NUM_DEF,
  parameter int HW             = $clog2(ACC_HEIGHT_NUM + 1),
  parameter int AW             = 8,
  parameter int OW             = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [HW-1:0] cfg_height,
  input  logic [AW-1:0] cfg_acc_num,
  input  logic [OW-1:0] cfg_tile_num,
  output logic          iss_vld,
  input  logic          iss_rdy,
  output logic [HW-1:0] iss_h,
  output logic [AW-1:0] iss_a,
  output logic [OW-1:0] iss_o,
  output logic          psum_vld,
  output logic          height_loop_end,
  output logic          acc_loop_max,
  output logic          acc_and_height_loop_end,
  input  logic          acc_out_vld,
  output logic          busy,
  output logic          done,
`ifdef ACC_LOOP_SEQ_PERF_EN
  output logic          cfg_err,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_cycle_cnt
`else
  output logic          cfg_err
`endif
);

  localparam int            CW           = HW + OW;
  localparam logic [HW-1:0] HEIGHT_LIMIT = HW'(ACC_HEIGHT_NUM);

  state_t        state, state_nxt;
  logic [HW-1:0] h_last;
  logic [AW-1:0] a_last;
  logic [OW-1:0] o_last;
  logic [CW-1:0] exp_total, out_cnt, out_cnt_nxt;
  logic          cfg_bad, start_ok, fire;
  logic          h_end, a_end, o_end, last_fire;
  flag_t         flag_p0, flag_pl;
  logic [FLAG_W-1:0] flag_dly;

  assign cfg_bad = (cfg_height == '0) || (cfg_height > HEIGHT_LIMIT) ||
                   (cfg_acc_num == '0) || (cfg_tile_num == '0);
  assign start_ok    = (state == ST_IDLE) && start && !cfg_bad;
  assign fire        = iss_vld && iss_rdy;
  assign h_end       = (iss_h == h_last);
  assign a_end       = (iss_a == a_last);
  assign o_end       = (iss_o == o_last);
  assign last_fire   = fire && h_end && a_end && o_end;
  assign out_cnt_nxt = out_cnt + CW'(acc_out_vld && busy);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: DRAIN also looks at this cycle's output beat so done follows it by one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
      ST_RUN:   if (last_fire) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_cnt_nxt >= exp_total) state_nxt = ST_FIN;
      ST_FIN:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the state
  always_comb begin
    iss_vld = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_RUN:   begin iss_vld = 1'b1; busy = 1'b1; end
      ST_DRAIN: busy = 1'b1;
      ST_FIN:   done = 1'b1;
      default:  ;
    endcase
  end

  // Latch loop limits and the expected output-beat total on any start seen in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_last    <= '0;
      a_last    <= '0;
      o_last    <= '0;
      exp_total <= '0;
    end else if ((state == ST_IDLE) && start) begin
      h_last    <= cfg_height - HW'(1);
      a_last    <= cfg_acc_num - AW'(1);
      o_last    <= cfg_tile_num - OW'(1);
      exp_total <= CW'(cfg_height) * CW'(cfg_tile_num);
    end
  end

  // Rejected start: one-cycle error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= (state == ST_IDLE) && start && cfg_bad;
  end

  // Nested loop counters, h innermost; the final point wraps everything back to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_h <= '0;
      iss_a <= '0;
      iss_o <= '0;
    end else if (start_ok) begin
      iss_h <= '0;
      iss_a <= '0;
      iss_o <= '0;
    end else if (fire) begin
      if (h_end) begin
        iss_h <= '0;
        if (a_end) begin
          iss_a <= '0;
          iss_o <= o_end ? '0 : iss_o + OW'(1);
        end else begin
          iss_a <= iss_a + AW'(1);
        end
      end else begin
        iss_h <= iss_h + HW'(1);
      end
    end
  end

  // Accumulator output beats seen while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        out_cnt <= '0;
    else if (start_ok) out_cnt <= '0;
    else               out_cnt <= out_cnt_nxt;
  end

  // ---- stage p0: flags of the beat firing this cycle ----
  always_comb begin
    flag_p0      = '0;
    flag_p0.vld  = fire;
    flag_p0.hle  = h_end;
    flag_p0.alm  = a_end;
    flag_p0.ahle = h_end && a_end;
  end

  acc_flag_delay #(
    .DEPTH (MAC_LAT),
    .W     (FLAG_W)
  ) u_flag_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (flag_p0),
    .dout  (flag_dly)
  );

  // ---- stage p<MAC_LAT>: flags aligned with the partial-sum valid ----
  assign flag_pl                 = flag_dly;
  assign psum_vld                = flag_pl.vld;
  assign height_loop_end         = flag_pl.hle  && flag_pl.vld;
  assign acc_loop_max            = flag_pl.alm  && flag_pl.vld;
  assign acc_and_height_loop_end = flag_pl.ahle && flag_pl.vld;

`ifdef ACC_LOOP_SEQ_PERF_EN
  // Saturating stall / busy cycle counters, cleared on an accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_cycle_cnt <= '0;
    end else if (start_ok) begin
      perf_stall_cnt <= '0;
      perf_cycle_cnt <= '0;
    end else begin
      if (iss_vld && !iss_rdy && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (busy && (perf_cycle_cnt != '1))
        perf_cycle_cnt <= perf_cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_acc_loop_sequencer.sv
// Scoreboard bench for acc_loop_sequencer: stimulus pushes expected issue
// beats and done cycles; a negedge monitor checks indices, flag alignment
// (fire cycle + MAC_LAT) and done timing as the DUT presents them.
module tb_acc_loop_sequencer;

  localparam int MAC_LAT        = 4;
  localparam int ACC_HEIGHT_NUM = 16;
  localparam int HW             = 5;
  localparam int AW             = 8;
  localparam int OW             = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [HW-1:0] cfg_height = '0;
  logic [AW-1:0] cfg_acc_num = '0;
  logic [OW-1:0] cfg_tile_num = '0;
  logic          iss_rdy = 1'b0;
  logic          acc_out_vld = 1'b0;
  logic          iss_vld, psum_vld, height_loop_end, acc_loop_max;
  logic          acc_and_height_loop_end, busy, done, cfg_err;
  logic [HW-1:0] iss_h;
  logic [AW-1:0] iss_a;
  logic [OW-1:0] iss_o;
`ifdef ACC_LOOP_SEQ_PERF_EN
  logic [31:0]   perf_stall_cnt, perf_cycle_cnt;
`endif

  acc_loop_sequencer #(
    .MAC_LAT        (MAC_LAT),
    .ACC_HEIGHT_NUM (ACC_HEIGHT_NUM),
    .HW             (HW),
    .AW             (AW),
    .OW             (OW)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start                   (start),
    .cfg_height              (cfg_height),
    .cfg_acc_num             (cfg_acc_num),
    .cfg_tile_num            (cfg_tile_num),
    .iss_vld                 (iss_vld),
    .iss_rdy                 (iss_rdy),
    .iss_h                   (iss_h),
    .iss_a                   (iss_a),
    .iss_o                   (iss_o),
    .psum_vld                (psum_vld),
    .height_loop_end         (height_loop_end),
    .acc_loop_max            (acc_loop_max),
    .acc_and_height_loop_end (acc_and_height_loop_end),
    .acc_out_vld             (acc_out_vld),
    .busy                    (busy),
    .done                    (done),
`ifdef ACC_LOOP_SEQ_PERF_EN
    .cfg_err                 (cfg_err),
    .perf_stall_cnt          (perf_stall_cnt),
    .perf_cycle_cnt          (perf_cycle_cnt)
`else
    .cfg_err                 (cfg_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int h; int a; int o;
    bit hle; bit alm; bit ahle;
  } beat_t;

  typedef struct {
    int cyc;
    bit hle; bit alm; bit ahle;
  } lat_t;

  beat_t exp_iss[$];
  lat_t  lat_q[$];
  int    exp_done[$];
  int    checks = 0;
  int    errors = 0;

  // Hand-computed beat table for H=3, A=2, O=1
  int t1_h   [6] = '{0, 1, 2, 0, 1, 2};
  int t1_a   [6] = '{0, 0, 0, 1, 1, 1};
  bit t1_hle [6] = '{0, 0, 1, 0, 0, 1};
  bit t1_alm [6] = '{0, 0, 0, 1, 1, 1};
  bit t1_ahle[6] = '{0, 0, 0, 0, 0, 1};

  // Rejected configurations
  int rj_h[4] = '{0, 17, 3, 3};
  int rj_a[4] = '{2, 2, 0, 2};
  int rj_o[4] = '{1, 1, 1, 0};

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string act, input string req);
    checks++;
    errors++;
    $display("FAIL %s actual=%s required=%s", name, act, req);
  endtask

  task automatic push_t1();
    beat_t b;
    for (int i = 0; i < 6; i++) begin
      b.h = t1_h[i]; b.a = t1_a[i]; b.o = 0;
      b.hle = t1_hle[i]; b.alm = t1_alm[i]; b.ahle = t1_ahle[i];
      exp_iss.push_back(b);
    end
  endtask

  task automatic push_model(input int hn, input int an, input int on, input int limit);
    beat_t b;
    int n = 0;
    for (int oo = 0; oo < on; oo++)
      for (int aa = 0; aa < an; aa++)
        for (int hh = 0; hh < hn; hh++)
          if (n < limit) begin
            b.h = hh; b.a = aa; b.o = oo;
            b.hle  = (hh == hn - 1);
            b.alm  = (aa == an - 1);
            b.ahle = b.hle && b.alm;
            exp_iss.push_back(b);
            n++;
          end
  endtask

  task automatic do_start(input int h, input int a, input int o);
    cfg_height   = HW'(h);
    cfg_acc_num  = AW'(a);
    cfg_tile_num = OW'(o);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: ready always; mode 1: ready pattern 1,0,0 repeating.
  // start_k >= 0 pulses a (to-be-ignored) start in that iteration.
  task automatic run_issue(input int mode, input int start_k, input int limit);
    int k = 0;
    while (exp_iss.size() != 0 && k < limit) begin
      iss_rdy = (mode == 0) ? 1'b1 : ((k % 3) == 0);
      if (k == start_k) begin
        start = 1'b1;
        cfg_height = HW'(1); cfg_acc_num = AW'(1); cfg_tile_num = OW'(1);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    if (exp_iss.size() != 0) begin
      fail("issue_timeout", "beats_pending", "all_issued");
      exp_iss.delete();
    end
  endtask

  task automatic feed_out(input int n, input bit start_in_fin);
    int last_c = 0;
    for (int i = 0; i < n; i++) begin
      acc_out_vld = 1'b1;
      last_c = cyc;
      @(posedge clk); #1;
    end
    acc_out_vld = 1'b0;
    exp_done.push_back(last_c + 1);
    if (start_in_fin) begin
      cfg_height = HW'(3); cfg_acc_num = AW'(2); cfg_tile_num = OW'(1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("fin_start_iss_vld", iss_vld, 0);
      chk("fin_start_busy", busy, 0);
    end
  endtask

  task automatic wait_quiet(input int limit);
    int n = 0;
    while ((lat_q.size() != 0 || exp_done.size() != 0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    if (lat_q.size() != 0 || exp_done.size() != 0) begin
      fail("drain_timeout", "events_pending", "all_seen");
      lat_q.delete();
      exp_done.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {iss_vld, psum_vld, height_loop_end, acc_loop_max,
               acc_and_height_loop_end, busy, done, cfg_err,
               iss_h, iss_a, iss_o}, 0);
  endtask

  beat_t mon_e;
  lat_t  mon_l;

  // Monitor: compares whatever the DUT presents against the queued expectations
  always @(negedge clk) begin
    if (!rst_n) begin
      lat_q.delete();
    end else begin
      if (iss_vld) begin
        if (exp_iss.size() == 0) begin
          fail("unexpected_iss_vld", "1", "0");
        end else begin
          mon_e = exp_iss[0];
          chk("iss_h", iss_h, mon_e.h);
          chk("iss_a", iss_a, mon_e.a);
          chk("iss_o", iss_o, mon_e.o);
          if (iss_rdy) begin
            mon_e = exp_iss.pop_front();
            mon_l.cyc  = cyc + MAC_LAT;
            mon_l.hle  = mon_e.hle;
            mon_l.alm  = mon_e.alm;
            mon_l.ahle = mon_e.ahle;
            lat_q.push_back(mon_l);
          end
        end
      end
      if (psum_vld) begin
        if (lat_q.size() == 0) begin
          fail("unexpected_psum_vld", "1", "0");
        end else begin
          mon_l = lat_q.pop_front();
          chk("psum_cycle", cyc, mon_l.cyc);
          chk("height_loop_end", height_loop_end, mon_l.hle);
          chk("acc_loop_max", acc_loop_max, mon_l.alm);
          chk("acc_and_height_loop_end", acc_and_height_loop_end, mon_l.ahle);
        end
      end else if (height_loop_end || acc_loop_max || acc_and_height_loop_end) begin
        fail("flag_without_psum_vld", "1", "0");
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          fail("unexpected_done", "1", "0");
        end else begin
          chk("done_cycle", cyc, exp_done.pop_front());
          chk("busy_at_done", busy, 0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
`ifdef ACC_LOOP_SEQ_PERF_EN
    chk("reset_perf_stall", perf_stall_cnt, 0);
    chk("reset_perf_cycle", perf_cycle_cnt, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

    // H=3 A=2 O=1, ready held high, start pulsed in the FIN cycle
    push_t1();
    do_start(3, 2, 1);
    run_issue(0, -1, 100);
    chk("t1_busy_drain", busy, 1);
    feed_out(3, 1'b1);
    wait_quiet(50);

    // Same layer with ready 1,0,0,..., start pulsed mid-RUN
    push_t1();
    do_start(3, 2, 1);
    run_issue(1, 4, 200);
    feed_out(3, 1'b0);
    wait_quiet(50);
`ifdef ACC_LOOP_SEQ_PERF_EN
    chk("perf_stall_cnt", perf_stall_cnt, 10);
`endif

    // Rejected configurations
    for (int i = 0; i < 4; i++) begin
      do_start(rj_h[i], rj_a[i], rj_o[i]);
      chk("rej_cfg_err", cfg_err, 1);
      chk("rej_busy", busy, 0);
      chk("rej_iss_vld", iss_vld, 0);
      @(posedge clk); #1;
      chk("rej_cfg_err_pulse", cfg_err, 0);
      chk("rej_iss_vld_after", iss_vld, 0);
    end

    // H=1 A=1 O=2: every beat carries all three flags
    iss_rdy = 1'b1;
    push_model(1, 1, 2, 2);
    do_start(1, 1, 2);
    run_issue(0, -1, 50);
    feed_out(2, 1'b0);
    wait_quiet(50);

    // Reset after beat 7 of an H=4 A=3 O=2 layer, then a clean full layer
    push_model(4, 3, 2, 7);
    do_start(4, 3, 2);
    run_issue(0, -1, 100);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_run_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("after_reset_release");
    push_model(4, 3, 2, 24);
    do_start(4, 3, 2);
    run_issue(0, -1, 200);
    feed_out(8, 1'b0);
    wait_quiet(50);

    chk("final_exp_iss_empty", exp_iss.size(), 0);
    chk("final_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_loop_sequencer.md
Name: acc_loop_sequencer

Overview:
- Upstream control partner of the output accumulator. It walks the height, accumulation and output-tile loops.
- Issues one MAC beat per loop point to the feature/weight fetch path using a valid/ready handshake.
- Emits the accumulator's loop flags (height-loop end, acc-loop max, acc-and-height-loop end). The flags are delayed by the fixed MAC pipeline latency so they arrive cycle-aligned with the partial-sum valid.
- Counts accumulator output beats to report layer completion.

Parameters:
- MAC_LAT, 4: cycles from an accepted issue beat to its partial sum at the accumulator input; legal range is 1 or more.
- ACC_HEIGHT_NUM, 16: depth of the accumulator's partial-sum memory, which is also the maximum cfg_height.
- HW, 5: width of the height config/index, equal to $clog2(ACC_HEIGHT_NUM+1).
- AW, 8: width of the acc-loop count and index.
- OW, 8: width of the output-tile count and index.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a layer; ignored unless in IDLE
- cfg_height  in  HW  number of height positions per pass, 1..ACC_HEIGHT_NUM
- cfg_acc_num  in  AW  number of accumulation passes, 1 or more
- cfg_tile_num  in  OW  number of output-channel tiles, 1 or more
- iss_vld  out  1  issue beat valid
- iss_rdy  in  1  fetch path accepts the beat
- iss_h  out  HW  height index of the current beat
- iss_a  out  AW  acc index of the current beat
- iss_o  out  OW  tile index of the current beat
- psum_vld  out  1  delayed issue valid, aligned with the accumulator data valid
- height_loop_end  out  1  aligned flag
- acc_loop_max  out  1  aligned flag
- acc_and_height_loop_end  out  1  aligned flag
- acc_out_vld  in  1  accumulator output-beat valid
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- All outputs reset to 0. Reset clears the FSM (to IDLE), all counters and every delay-line stage.
- A reset mid-layer abandons the layer with no done pulse. The accumulator shares rst_n, so no stale partial sums survive.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE, on start: config is latched.
  - If cfg_height==0, cfg_height>ACC_HEIGHT_NUM, cfg_acc_num==0 or cfg_tile_num==0: cfg_err pulses the next cycle and the FSM stays in IDLE.
  - Otherwise the FSM moves to RUN and iss_vld rises the next cycle.
- RUN:
  - iss_vld=1 throughout. Indices are stable while iss_vld is high and iss_rdy is low.
  - Loop order is h innermost, then a, then o outermost. Counters advance only on a fire (iss_vld & iss_rdy).
  - h wraps at cfg_height-1 and carries into a; a wraps at cfg_acc_num-1 and carries into o.
  - On the fire of the last point (all three indices at max) the FSM moves to DRAIN and iss_vld drops the next cycle.
- Flags computed at each fire:
  - hle = (h==H-1)
  - alm = (a==A-1)
  - ahle = hle & alm
- Delay line: MAC_LAT register stages of {fire, hle, alm, ahle}. The outputs are the last stage, with every flag ANDed with psum_vld, so flags are 0 whenever psum_vld is 0.
- Output counting:
  - out_cnt, of width HW+OW, increments on each acc_out_vld while busy.
  - The expected total is cfg_height*cfg_tile_num, computed once when config is latched.
  - acc_out_vld while not busy is ignored.
- DRAIN: when out_cnt reaches the expected total, the FSM moves to FIN.
- FIN: done=1 for exactly one cycle, then IDLE.
  - busy falls in the same cycle done rises.
  - A start in the FIN cycle is ignored.
- Throughput: one beat per cycle when iss_rdy is held high. Iteration adds no bubbles at loop wraps.
- Simultaneous events:
  - A fire and acc_out_vld in the same cycle are both honoured.
  - The last fire and the final acc_out_vld cannot coincide, since the final output always lags the last fire by at least MAC_LAT.

Optional Feature:
- Macro: ACC_LOOP_SEQ_PERF_EN.
- When defined, two extra outputs are added:
  - perf_stall_cnt [31:0]: counts RUN cycles with iss_vld & !iss_rdy.
  - perf_cycle_cnt [31:0]: counts busy cycles.
  - Both clear on an accepted start, saturate at all-ones, and hold after done.
- When not defined, neither port exists and there is no counter logic.

Decomposition:
- Shared package/header holds:
  - FSM state encoding
  - default values of ACC_HEIGHT_NUM and MAC_LAT, matching the accumulator's depth and delay constants
  - a flag-bundle typedef {vld, hle, alm, ahle}
- One natural sub-module: acc_flag_delay, a parameterised shift register (width 4, depth MAC_LAT) with reset clear.
- Everything else stays in the top level.

Test Plan:
- H=3, A=2, O=1, iss_rdy=1, MAC_LAT=4:
  - 6 fires, psum_vld on cycles 5..10 after the first fire.
  - height_loop_end on beats 3 and 6.
  - acc_loop_max on beats 4..6.
  - acc_and_height_loop_end only on beat 6.
  - Feeding 3 acc_out_vld gives done one cycle after the 3rd.
- Same config with iss_rdy toggling 1,0,0,1,...:
  - Indices hold during stalls.
  - Flag sequence is unchanged.
  - PERF_EN build reports perf_stall_cnt equal to the number of stalled cycles.
- Rejected configs (cfg_height=0, cfg_height=17, cfg_acc_num=0, cfg_tile_num=0): each gives a cfg_err pulse, busy stays 0, no iss_vld.
- H=1, A=1, O=2: every beat carries all three flags; done after 2 output beats.
- rst_n pulsed low mid-RUN (H=4, A=3, O=2, after beat 7): all outputs 0 immediately. A fresh start runs a clean 24-beat layer from h=a=o=0.
- start pulsed during RUN and during FIN: ignored, with no change to indices or beat count.
